// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-entry output slot feeding the D-stage register,
// with stall hold, taken-branch redirect and delay-slot handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        delay,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] Instr,
    output logic [31:0] PC
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        EMPTY      = 2'd0,
        EMPTY_PEND = 2'd1,
        FULL       = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   fetch_pc_nx;
    logic [XLEN-1:0]   buf_instr;
    logic [XLEN-1:0]   buf_instr_nx;
    logic [XLEN-1:0]   buf_pc;
    logic [XLEN-1:0]   buf_pc_nx;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   target_nx;
    logic              valid;
    logic              capture;

    assign valid     = (state == FULL);
    assign imem_addr = fetch_pc;
    // Bubble (nop, PC 0) whenever the slot is empty; driven only from registers.
    assign Instr     = valid ? buf_instr : '0;
    assign PC        = valid ? buf_pc    : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            fetch_pc  <= RESET_PC;
            buf_instr <= '0;
            buf_pc    <= '0;
            target    <= '0;
        end else begin
            state     <= state_nx;
            fetch_pc  <= fetch_pc_nx;
            buf_instr <= buf_instr_nx;
            buf_pc    <= buf_pc_nx;
            target    <= target_nx;
        end
    end

    // Next-state, fetch address and slot capture.
    always_comb begin
        state_nx     = state;
        fetch_pc_nx  = fetch_pc;
        buf_instr_nx = buf_instr;
        buf_pc_nx    = buf_pc;
        target_nx    = target;
        capture      = 1'b0;
        imem_req     = !valid || !delay;

        case (state)
            EMPTY: begin
                // A redirect here means the delay slot is still in flight.
                if (imem_ready) begin
                    capture     = 1'b1;
                    state_nx    = FULL;
                    fetch_pc_nx = (redirect && !delay) ? redirect_pc : fetch_pc + XLEN'(4);
                end else if (redirect && !delay) begin
                    state_nx  = EMPTY_PEND;
                    target_nx = redirect_pc;
                end
            end
            EMPTY_PEND: begin
                if (imem_ready) begin
                    capture     = 1'b1;
                    state_nx    = FULL;
                    fetch_pc_nx = target;
                end
            end
            FULL: begin
                // Slot is consumed on any non-stalled edge; a redirect drops the in-flight word.
                if (!delay) begin
                    if (redirect) begin
                        state_nx    = EMPTY;
                        fetch_pc_nx = redirect_pc;
                    end else if (imem_ready) begin
                        capture     = 1'b1;
                        fetch_pc_nx = fetch_pc + XLEN'(4);
                    end else begin
                        state_nx = EMPTY;
                    end
                end
            end
            default: state_nx = EMPTY;
        endcase

        if (capture) begin
            buf_instr_nx = imem_rdata;
            buf_pc_nx    = fetch_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a
// cycle-level reference of the slot/pending rules.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        delay;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] key;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_pend;
    logic [31:0] m_tgt;
    logic [31:0] m_bi;
    logic [31:0] m_bp;

    always #5 clk = ~clk;

    // Memory returns a keyed image of the requested address.
    assign imem_rdata = imem_addr ^ key;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .delay       (delay),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .Instr       (Instr),
        .PC          (PC)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_valid = 1'b0;
        m_pend  = 1'b0;
        m_tgt   = '0;
        m_bi    = '0;
        m_bp    = '0;
    endtask

    // One clock edge of the fetch rules, applied to the reference state.
    task automatic model_step(input logic d, input logic r, input logic [31:0] rpc, input logic rdy);
        logic was_valid;
        was_valid = m_valid;
        if (was_valid && d) begin
            m_valid = 1'b1;
        end else if (was_valid && r) begin
            m_valid = 1'b0;
            m_pc    = rpc;
        end else if (rdy) begin
            m_bi    = m_pc ^ key;
            m_bp    = m_pc;
            m_valid = 1'b1;
            if (m_pend) begin
                m_pc   = m_tgt;
                m_pend = 1'b0;
            end else if (!was_valid && r && !d) begin
                m_pc = rpc;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end else begin
            m_valid = 1'b0;
            if (!was_valid && !m_pend && r && !d) begin
                m_pend = 1'b1;
                m_tgt  = rpc;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check32({tag, "_instr"}, Instr, m_valid ? m_bi : 32'h0);
        check32({tag, "_pc"}, PC, m_valid ? m_bp : 32'h0);
        check32({tag, "_req"}, 32'(imem_req), 32'(!m_valid || !delay));
        check32({tag, "_addr"}, imem_addr, m_pc);
    endtask

    // Entered and left at posedge+1.
    task automatic step(input logic d, input logic r, input logic [31:0] rpc, input logic rdy);
        delay       = d;
        redirect    = r;
        redirect_pc = rpc;
        imem_ready  = rdy;
        #1;
        check_outputs("step");
        @(posedge clk);
        model_step(d, r, rpc, rdy);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        delay      = 1'b0;
        redirect   = 1'b0;
        imem_ready = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs("rst");
        check32("rst_addr", imem_addr, RST_PC);
        check32("rst_req", 32'(imem_req), 32'd1);
        reset = 1'b1;
    endtask

    initial begin
        key         = '0;
        redirect_pc = '0;
        do_reset();

        // Streaming with ready tied high, then a 3-cycle stall at 0x3008.
        step(0, 0, 0, 1);
        check32("stream0", PC, 32'h3000);
        check32("stream0_i", Instr, 32'h3000);
        step(0, 0, 0, 1);
        check32("stream1", PC, 32'h3004);
        step(0, 0, 0, 1);
        check32("stream2", PC, 32'h3008);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1);
            check32("stall_hold", PC, 32'h3008);
        end
        step(0, 0, 0, 1);
        check32("stall_resume", PC, 32'h300C);

        // Two wait cycles per fetch.
        do_reset();
        for (int i = 0; i < 9; i++) step(0, 0, 0, (i % 3) == 2);
        check32("wait_pc", PC, 32'h3008);

        // Redirect while FULL at 0x3004.
        do_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check32("redir_full_pc", PC, 32'h3004);
        step(0, 1, 32'h3100, 1);
        check32("redir_bubble", Instr, 32'h0);
        step(0, 0, 0, 1);
        check32("redir_target", PC, 32'h3100);

        // Redirect while EMPTY with the delay slot waiting.
        do_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 1, 32'h3100, 0);
        step(0, 1, 32'h3200, 0);
        step(0, 0, 0, 1);
        check32("dslot_pc", PC, 32'h3008);
        step(0, 0, 0, 1);
        check32("dslot_target", PC, 32'h3100);

        // Redirect in EMPTY with ready high, target at the top of the address space.
        do_reset();
        step(0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 1);
        check32("wrap_top", PC, 32'hFFFF_FFFC);
        check32("wrap_addr", imem_addr, 32'h0);
        step(0, 0, 0, 1);
        check32("wrap_zero", PC, 32'h0);

        // Reset asserted mid-wait at fetch address 0x3010.
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check32("pre_rst_addr", imem_addr, 32'h3010);
        #2;
        reset      = 1'b0;
        imem_ready = 1'b1;
        #1;
        check32("async_instr", Instr, 32'h0);
        check32("async_pc", PC, 32'h0);
        check32("async_addr", imem_addr, RST_PC);
        @(posedge clk);
        #1;
        check32("rst_ignore_ready", Instr, 32'h0);
        reset = 1'b1;
        model_reset();
        step(0, 0, 0, 1);
        check32("post_rst_pc", PC, 32'h3000);

        // Randomized traffic.
        key = $urandom;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tpc;
            tpc = $urandom;
            tpc[1:0] = 2'b00;
            step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, tpc, $urandom_range(0, 9) < 6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
